// File: rtl/quadra_inv.sv
// Inverse solver for quadra: bit-serial bisection for the largest x with f(x) <= target.
// Define QUADRA_INV_EARLY_EXIT_EN to stop at the first probe that hits the target exactly.
module quadra_inv #(
    parameter int X_W        = 24,
    parameter int Y_W        = 24,
    parameter int Y_SIGNED   = 0,
    parameter int QUADRA_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [Y_W-1:0] req_target,
    output logic [X_W-1:0] probe_x,
    input  logic [Y_W-1:0] probe_y,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [X_W-1:0] rsp_x,
    output logic           rsp_exact,
    output logic           rsp_under
);

    localparam int IW = $clog2(X_W + 1);
    localparam int CW = (QUADRA_LAT > 1) ? $clog2(QUADRA_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // rsp_valid, once raised, holds with stable rsp_* until rsp_ready is seen.
    state_t         state_q, state_d;
    logic [Y_W-1:0] target_q, target_d;
    logic [X_W-1:0] result_q, result_d;
    logic [X_W-1:0] probe_q, probe_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           exact_q, exact_d;
    logic           under_q, under_d;

    logic           le;
    logic           eq;
    logic [X_W-1:0] kept;
    logic [X_W-1:0] one_x;

    assign one_x = {{(X_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            result_q <= '0;
            probe_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            exact_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            result_q <= result_d;
            probe_q  <= probe_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            exact_q  <= exact_d;
            under_q  <= under_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        result_d = result_q;
        probe_d  = probe_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        exact_d  = exact_q;
        under_d  = under_q;

        if (Y_SIGNED != 0) le = ($signed(probe_y) <= $signed(target_q));
        else               le = (probe_y <= target_q);
        eq   = (probe_y == target_q);
        kept = le ? probe_q : result_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    result_d = '0;
                    probe_d  = '0;
                    idx_d    = IW'(X_W);
                    cnt_d    = '0;
                    exact_d  = 1'b0;
                    under_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QUADRA_LAT - 1)) state_d = EVAL;
            end
            EVAL: begin
                if (idx_q == IW'(X_W)) begin
                    // Zero probe: decides the underflow case before any bit is tried.
                    if (!le) begin
                        under_d  = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        exact_d = eq;
                        idx_d   = IW'(X_W - 1);
                        probe_d = one_x << (X_W - 1);
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end else begin
                    result_d = kept;
                    if (le) exact_d = eq;
                    if (idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        probe_d = kept | (one_x << (idx_q - IW'(1)));
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
`ifdef QUADRA_INV_EARLY_EXIT_EN
                    if (eq) state_d = DONE;
`endif
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign probe_x   = probe_q;
    assign rsp_x     = result_q;
    assign rsp_exact = exact_q;
    assign rsp_under = under_q;

endmodule
